iter_div_axis: RTL and testbench
================================

Name: iter_div_axis

Overview:
- Multi-cycle 32-bit integer divider with an AXI-stream-style operand/result interface.
- It is the responder that the execute stage's DIV/DIVU issue logic drives.
- Two instances sit inside the execute stage: one with SIGNED=1 (DIV) and one with SIGNED=0 (DIVU).
- Replaces the vendor divider IP with team-owned RTL using a radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- SIGNED, 1, 1 = two's-complement operands and results; 0 = unsigned.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- s_axis_divisor_tdata  input  32  divisor operand
- s_axis_divisor_tvalid  input  1  divisor valid
- s_axis_divisor_tready  output  1  divisor channel can accept
- s_axis_dividend_tdata  input  32  dividend operand
- s_axis_dividend_tvalid  input  1  dividend valid
- s_axis_dividend_tready  output  1  dividend channel can accept
- m_axis_dout_tvalid  output  1  result valid, one-cycle pulse, no backpressure
- m_axis_dout_tdata  output  64  [63:32] quotient, [31:0] remainder

Behaviour:
- Decided: reset is synchronous and active-high; clock is clk.
- Reset values: both treadys = 1, m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0, state IDLE, both operand-holding flags cleared.
- Channels are independent. Each has a one-entry holding register plus a "full" flag.
  - tready = (state==IDLE) && !full.
  - Handshake = tvalid && tready at a rising edge; tdata is captured and full is set.
  - Channels may handshake in the same cycle or in different cycles, in either order.
  - tdata changes after a channel's handshake are ignored.
- States and transitions:
  - IDLE -> PREP at the edge where both full flags are (or become) set. Call that edge E0.
  - PREP (1 cycle):
    - Load magnitudes: |x| when SIGNED, raw otherwise.
    - Record qneg = sign(dividend) XOR sign(divisor) and rneg = sign(dividend); both are 0 when unsigned.
    - Clear the partial remainder and iteration counter; go to ITER at E0+1.
  - ITER (32 cycles, counter 0..31):
    - Shift the partial remainder left, bringing in the dividend MSB.
    - Trial-subtract the divisor; if no borrow, keep the difference and set the quotient bit to 1, else 0.
    - Done at E0+33 when counter==31, then go to FIX.
  - FIX (1 cycle):
    - Negate the quotient if qneg and the remainder if rneg.
    - Register into m_axis_dout_tdata at E0+34; go to DONE.
  - DONE (1 cycle): m_axis_dout_tvalid = 1. At E0+35, clear tvalid and both full flags and go to IDLE; treadys return to 1.
- Latency: m_axis_dout_tvalid is high exactly during the cycle between E0+34 and E0+35.
- m_axis_dout_tdata holds its value until the next FIX. Back-to-back issue earliest: a new handshake is possible at edge E0+36.
- Arithmetic: 33-bit trial subtraction. Magnitude of 0x80000000 is 0x80000000, handled as unsigned 32-bit.
- Boundary cases:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend (original, unsigned-interpreted bits), in both modes. Latency is unchanged.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. No trap.
  - Dividend 0: quotient = 0, remainder = 0 (unless the divisor is also 0, which falls under divide by zero).
  - tvalid asserted outside IDLE: tready = 0, no capture; the requester must hold tvalid.
  - Reset mid-operation (any state): abort the computation, apply reset values next cycle, no tvalid pulse.
  - tvalid dropped on one channel after the other has handshaked: the captured operand is retained and the block waits indefinitely in IDLE.

Test Plan:
- SIGNED=1, same-cycle handshake with dividend=-7 (0xFFFFFFF9), divisor=2 -> tvalid pulse 34 edges after capture; tdata = {0xFFFFFFFD, 0xFFFFFFFF}; pulse width exactly 1 cycle.
- SIGNED=1, dividend=7, divisor=-2, with the divisor handshaked 5 cycles before the dividend -> divisor tready low after its capture; tdata = {0xFFFFFFFD, 0x00000001}; latency counted from the dividend edge.
- SIGNED=0, dividend=0xFFFFFFFF, divisor=0x10 -> {0x0FFFFFFF, 0x0000000F}. Also 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Both modes, divisor=0, dividend=0x12345678 -> {0xFFFFFFFF, 0x12345678}. SIGNED=1, 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}.
- Back-to-back issue: 100/7 then 0x2A/6 with tvalid held high continuously -> second capture at edge E0+36; results {14, 2} then {7, 0}; operands presented during busy cycles are not captured.
- Reset asserted in ITER at counter 10 -> no tvalid pulse; treadys = 1 the cycle after reset; a fresh 9/3 afterwards yields {3, 0}.

Source files
------------

// File: rtl/iter_div_axis.sv
// iter_div_axis: multi-cycle radix-2 restoring 32-bit divider with AXI-stream operand/result channels
module iter_div_axis #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, state_n;
  logic dvd_full, dvs_full, dvd_hs, dvs_hs, qneg, rneg, ok;
  logic [31:0] dvd, dvs, d, q, rem, sub;
  logic [32:0] sh;
  logic [4:0] cnt;
  function automatic logic [31:0] mag(input logic [31:0] x);
    return (SIGNED && x[31]) ? -x : x;
  endfunction
  assign s_axis_dividend_tready = state == IDLE && !dvd_full;
  assign s_axis_divisor_tready = state == IDLE && !dvs_full;
  assign dvd_hs = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign dvs_hs = s_axis_divisor_tvalid && s_axis_divisor_tready;
  // q holds the remaining dividend bits in its MSBs and collects quotient bits at its LSB
  assign sh = {rem, q[31]};
  assign ok = sh >= {1'b0, d};
  assign sub = sh[31:0] - d;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = ((dvd_full || dvd_hs) && (dvs_full || dvs_hs)) ? PREP : IDLE;
      PREP: state_n = ITER;
      ITER: state_n = (cnt == 5'd31) ? FIX : ITER;
      FIX: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      dvd <= '0;
      dvs <= '0;
      dvd_full <= 1'b0;
      dvs_full <= 1'b0;
      d <= '0;
      q <= '0;
      rem <= '0;
      cnt <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata <= '0;
    end else begin
      if (dvd_hs) begin
        dvd <= s_axis_dividend_tdata;
        dvd_full <= 1'b1;
      end
      if (dvs_hs) begin
        dvs <= s_axis_divisor_tdata;
        dvs_full <= 1'b1;
      end
      m_axis_dout_tvalid <= state == FIX;
      case (state)
        PREP: begin
          q <= mag(dvd);
          d <= mag(dvs);
          rem <= '0;
          cnt <= '0;
          qneg <= SIGNED && (dvd[31] ^ dvs[31]);
          rneg <= SIGNED && dvd[31];
        end
        ITER: begin
          rem <= ok ? sub : sh[31:0];
          q <= {q[30:0], ok};
          cnt <= cnt + 5'd1;
        end
        // divide by zero reports the raw dividend, bypassing sign fix-up
        FIX: m_axis_dout_tdata <= (dvs == '0) ? {32'hFFFF_FFFF, dvd} : {qneg ? -q : q, rneg ? -rem : rem};
        DONE: begin
          dvd_full <= 1'b0;
          dvs_full <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_iter_div_axis.sv
// tb_iter_div_axis: drives a signed and an unsigned divider with the same directed vectors and checks both every cycle
module tb_iter_div_axis;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] dvs_data = '0, dvd_data = '0;
  logic dvs_valid = 1'b0, dvd_valid = 1'b0;
  logic rdy_dvs_s, rdy_dvd_s, vs, rdy_dvs_u, rdy_dvd_u, vu;
  logic [63:0] ds, du, last_s = '0, last_u = '0;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int c; logic [63:0] es; logic [63:0] eu;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  iter_div_axis #(.SIGNED(1'b1)) u_s (
    .clk(clk), .reset(reset),
    .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(rdy_dvs_s),
    .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(rdy_dvd_s),
    .m_axis_dout_tvalid(vs), .m_axis_dout_tdata(ds)
  );
  iter_div_axis #(.SIGNED(1'b0)) u_u (
    .clk(clk), .reset(reset),
    .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(rdy_dvs_u),
    .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(rdy_dvd_u),
    .m_axis_dout_tvalid(vu), .m_axis_dout_tdata(du)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", n, a, e, cyc);
    end
  endtask
  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
    end
    return {a / b, a % b};
  endfunction
  always @(negedge clk)
    if (!reset) begin
      logic ev;
      ev = q.size() > 0 && q[0].c == cyc;
      if (ev) begin
        last_s = q[0].es;
        last_u = q[0].eu;
        void'(q.pop_front());
      end
      chk("tvalid_s", {63'b0, vs}, {63'b0, ev});
      chk("tvalid_u", {63'b0, vu}, {63'b0, ev});
      chk("tdata_s", ds, last_s);
      chk("tdata_u", du, last_u);
    end
  task automatic rdy(input string n, input logic e_dvd, input logic e_dvs);
    chk({n, "_dvd_s"}, {63'b0, rdy_dvd_s}, {63'b0, e_dvd});
    chk({n, "_dvs_s"}, {63'b0, rdy_dvs_s}, {63'b0, e_dvs});
    chk({n, "_dvd_u"}, {63'b0, rdy_dvd_u}, {63'b0, e_dvd});
    chk({n, "_dvs_u"}, {63'b0, rdy_dvs_u}, {63'b0, e_dvs});
  endtask
  task automatic expect_op(input int e0, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] hs, input logic [63:0] hu);
    chk("model_s", model(1'b1, a, b), hs);
    chk("model_u", model(1'b0, a, b), hu);
    q.push_back('{e0 + 34, model(1'b1, a, b), model(1'b0, a, b)});
  endtask
  task automatic drain();
    for (int i = 0; i < 80 && q.size() > 0; i++) @(posedge clk);
    chk("timeout", 64'(q.size()), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rdy("idle", 1'b1, 1'b1);
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input int gap,
                       input logic [63:0] hs, input logic [63:0] hu);
    @(posedge clk);
    #1;
    dvs_data = b;
    dvs_valid = 1'b1;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
      dvs_valid = 1'b0;
      dvs_data = 32'hDEAD_BEEF;
      rdy("dvs_held", 1'b1, 1'b0);
    end
    dvd_data = a;
    dvd_valid = 1'b1;
    expect_op(cyc + 1, a, b, hs, hu);
    @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    dvd_data = 32'hCAFE_F00D;
    rdy("busy", 1'b0, 1'b0);
    drain();
  endtask
  initial begin
    int e0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rdy("reset", 1'b1, 1'b1);
    chk("reset_tvalid", {62'b0, vs, vu}, 64'd0);
    chk("reset_tdata", ds | du, 64'd0);
    issue(32'hFFFF_FFF9, 32'd2, 0, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, {32'h7FFF_FFFC, 32'h1});
    issue(32'd7, 32'hFFFF_FFFE, 5, {32'hFFFF_FFFD, 32'h1}, {32'h0, 32'h7});
    issue(32'hFFFF_FFFF, 32'h10, 0, {32'h0, 32'hFFFF_FFFF}, {32'h0FFF_FFFF, 32'hF});
    issue(32'h8000_0000, 32'hFFFF_FFFF, 0, {32'h8000_0000, 32'h0}, {32'h0, 32'h8000_0000});
    issue(32'h1234_5678, 32'd0, 0, {32'hFFFF_FFFF, 32'h1234_5678}, {32'hFFFF_FFFF, 32'h1234_5678});
    issue(32'hFFFF_FFF9, 32'd0, 2, {32'hFFFF_FFFF, 32'hFFFF_FFF9}, {32'hFFFF_FFFF, 32'hFFFF_FFF9});
    issue(32'd0, 32'd5, 0, 64'd0, 64'd0);
    // back-to-back with valids held high; new operands must wait for E0+36
    @(posedge clk);
    #1;
    dvd_data = 32'd100;
    dvs_data = 32'd7;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    e0 = cyc + 1;
    expect_op(e0, 32'd100, 32'd7, {32'd14, 32'd2}, {32'd14, 32'd2});
    expect_op(e0 + 36, 32'h2A, 32'd6, {32'd7, 32'd0}, {32'd7, 32'd0});
    @(posedge clk);
    #1;
    dvd_data = 32'h2A;
    dvs_data = 32'd6;
    rdy("b2b_busy", 1'b0, 1'b0);
    while (cyc < e0 + 36) @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    drain();
    // abort in ITER with counter at 10
    @(posedge clk);
    #1;
    dvd_data = 32'd100;
    dvs_data = 32'd7;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    while (cyc < e0 + 11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_s = '0;
    last_u = '0;
    rdy("after_reset", 1'b1, 1'b1);
    chk("after_reset_tvalid", {62'b0, vs, vu}, 64'd0);
    repeat (40) @(posedge clk);
    issue(32'd9, 32'd3, 0, {32'd3, 32'd0}, {32'd3, 32'd0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
